n64_poll_scheduler: RTL and testbench

//  Time-slot scheduler sharing one N64 one-wire transceiver engine between two player controller lines.

---
 rtl/n64_pkg.sv | 36 +++
 rtl/n64_port_status.sv | 48 ++++
 rtl/n64_poll_scheduler.sv | 130 +++++++++++++
 tb/tb_n64_poll_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// rtl/n64_pkg.sv - shared constants for the N64 controller poll scheduler
// FSM encodings and button-word bit positions of the 32-bit controller payload.
package n64_pkg;

   localparam int N64_RESP_W = 34;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_WAIT_SLOT = 3'd1;
   localparam state_t ST_ISSUE     = 3'd2;
   localparam state_t ST_AWAIT     = 3'd3;
   localparam state_t ST_COMMIT    = 3'd4;

   localparam int BTN_A          = 31;
   localparam int BTN_B          = 30;
   localparam int BTN_Z          = 29;
   localparam int BTN_START      = 28;
   localparam int BTN_DPAD_UP    = 27;
   localparam int BTN_DPAD_DOWN  = 26;
   localparam int BTN_DPAD_LEFT  = 25;
   localparam int BTN_DPAD_RIGHT = 24;
   localparam int STICK_X_MSB    = 15;
   localparam int STICK_X_LSB    = 8;
   localparam int STICK_Y_MSB    = 7;
   localparam int STICK_Y_LSB    = 0;

   function automatic logic signed [7:0] stick_x(input logic [31:0] word);
      return word[STICK_X_MSB:STICK_X_LSB];
   endfunction

   function automatic logic signed [7:0] stick_y(input logic [31:0] word);
      return word[STICK_Y_MSB:STICK_Y_LSB];
   endfunction

endpackage

// File: rtl/n64_port_status.sv
// rtl/n64_port_status.sv - per-port button latch, miss counter and connection flag
// Consumes one-cycle hit/miss strobes from the scheduler's COMMIT state.
module n64_port_status
   import n64_pkg::*;
#(
   parameter int MAX_MISSES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hit,
   input  logic        miss,
   input  logic [31:0] payload,
   output logic [31:0] btn,
   output logic        upd,
   output logic        conn
);

   localparam int MW = $clog2(MAX_MISSES + 1);
   localparam logic [MW-1:0] MISS_MAX  = MW'(MAX_MISSES);
   localparam logic [MW-1:0] MISS_LAST = MW'(MAX_MISSES - 1);

   logic [MW-1:0] miss_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn      <= '0;
         upd      <= 1'b0;
         conn     <= 1'b0;
         miss_cnt <= '0;
      end else begin
         upd <= hit;
         if (hit) begin
            btn      <= payload;
            miss_cnt <= '0;
            conn     <= 1'b1;
         end else if (miss) begin
            if (miss_cnt != MISS_MAX)
               miss_cnt <= miss_cnt + 1'b1;
            // Neutral buttons on disconnect so the paddle logic stops moving.
            if (miss_cnt >= MISS_LAST) begin
               conn <= 1'b0;
               btn  <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/n64_poll_scheduler.sv
// rtl/n64_poll_scheduler.sv - round-robin slot scheduler for two N64 controller lines
// Shares one transceiver engine: issue, await response or timeout, commit to the selected port.
module n64_poll_scheduler
   import n64_pkg::*;
#(
   parameter int SLOT_CYCLES    = 208_333,
   parameter int TIMEOUT_CYCLES = 12_500,
   parameter int MAX_MISSES     = 3,
   parameter bit CHECK_PARAMS   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   output logic                  eng_start,
   output logic                  eng_sel,
   input  logic [N64_RESP_W-1:0] eng_data,
   input  logic                  eng_valid,
   output logic [31:0]           btn0,
   output logic [31:0]           btn1,
   output logic                  upd0,
   output logic                  upd1,
   output logic [1:0]            conn,
   output logic                  overrun
);

   localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   generate
      if (CHECK_PARAMS && ((TIMEOUT_CYCLES + 4 >= SLOT_CYCLES) || (MAX_MISSES < 1))) begin : g_bad_params
         $error("n64_poll_scheduler: need TIMEOUT_CYCLES + 4 < SLOT_CYCLES and MAX_MISSES >= 1");
      end
   endgenerate

   state_t        state;
   logic [SW-1:0] slot_cnt;
   logic [TW-1:0] to_cnt;
   logic          slot_tick;
   logic          hit_r;
   logic [31:0]   data_r;
   logic          hit_s;
   logic          miss_s;
   logic          unused_framing;

   assign unused_framing = ^eng_data[N64_RESP_W-1:32];

   assign slot_tick = enable && (slot_cnt == SW'(SLOT_CYCLES - 1));
   assign eng_start = (state == ST_ISSUE);
   assign hit_s     = (state == ST_COMMIT) && hit_r;
   assign miss_s    = (state == ST_COMMIT) && !hit_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         slot_cnt <= '0;
      else if (!enable || slot_tick)
         slot_cnt <= '0;
      else
         slot_cnt <= slot_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         eng_sel <= 1'b0;
         to_cnt  <= '0;
         hit_r   <= 1'b0;
         data_r  <= '0;
      end else begin
         case (state)
            ST_IDLE:
               if (enable) state <= ST_WAIT_SLOT;
            ST_WAIT_SLOT:
               if (!enable)        state <= ST_IDLE;
               else if (slot_tick) state <= ST_ISSUE;
            ST_ISSUE: begin
               to_cnt <= '0;
               hit_r  <= 1'b0;
               state  <= ST_AWAIT;
            end
            ST_AWAIT:
               // A response landing on the final timeout cycle still wins.
               if (eng_valid) begin
                  hit_r  <= 1'b1;
                  data_r <= eng_data[31:0];
                  state  <= ST_COMMIT;
               end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  state <= ST_COMMIT;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            ST_COMMIT: begin
               eng_sel <= ~eng_sel;
               state   <= enable ? ST_WAIT_SLOT : ST_IDLE;
            end
            default:
               state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overrun <= 1'b0;
      else if (slot_tick && (state != ST_WAIT_SLOT))
         overrun <= 1'b1;
   end

   n64_port_status #(.MAX_MISSES(MAX_MISSES)) u_port0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .hit     (hit_s && !eng_sel),
      .miss    (miss_s && !eng_sel),
      .payload (data_r),
      .btn     (btn0),
      .upd     (upd0),
      .conn    (conn[0])
   );

   n64_port_status #(.MAX_MISSES(MAX_MISSES)) u_port1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .hit     (hit_s && eng_sel),
      .miss    (miss_s && eng_sel),
      .payload (data_r),
      .btn     (btn1),
      .upd     (upd1),
      .conn    (conn[1])
   );

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// tb/tb_n64_poll_scheduler.sv - scoreboard bench for n64_poll_scheduler
// Engine model pushes expected updates; a monitor pops them on every upd pulse.
module tb_n64_poll_scheduler;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        eng_start;
   logic        eng_sel;
   logic [33:0] eng_data;
   logic        eng_valid;
   logic [31:0] btn0, btn1;
   logic        upd0, upd1;
   logic [1:0]  conn;
   logic        overrun;

   logic        enable2;
   logic        eng_start2;
   logic        eng_sel2;
   logic [33:0] eng_data2;
   logic        eng_valid2;
   logic [31:0] btn0_2, btn1_2;
   logic        upd0_2, upd1_2;
   logic [1:0]  conn2;
   logic        overrun2;

   n64_poll_scheduler #(.SLOT_CYCLES(100), .TIMEOUT_CYCLES(20), .MAX_MISSES(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .eng_start(eng_start), .eng_sel(eng_sel),
      .eng_data(eng_data), .eng_valid(eng_valid), .btn0(btn0), .btn1(btn1),
      .upd0(upd0), .upd1(upd1), .conn(conn), .overrun(overrun)
   );

   n64_poll_scheduler #(.SLOT_CYCLES(16), .TIMEOUT_CYCLES(20), .MAX_MISSES(3), .CHECK_PARAMS(1'b0)) u_ovr (
      .clk(clk), .rst_n(rst_n), .enable(enable2), .eng_start(eng_start2), .eng_sel(eng_sel2),
      .eng_data(eng_data2), .eng_valid(eng_valid2), .btn0(btn0_2), .btn1(btn1_2),
      .upd0(upd0_2), .upd1(upd1_2), .conn(conn2), .overrun(overrun2)
   );

   typedef struct {
      int          port;
      logic [31:0] btn;
      longint      cyc;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   longint      cyc = 0;

   logic [1:0]  resp_en;
   int          resp_delay;
   logic [31:0] data0, data1;
   int          stray_cnt;
   int          n_starts = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Engine model: answers each start after resp_delay cycles for enabled ports.
   initial begin
      int          cd;
      logic        exp_sel;
      int          pend_port;
      logic [31:0] pend_data;
      longint      last_start;
      bit          have_last;
      int          stray_done;
      cd = -1; exp_sel = 1'b0; have_last = 1'b0; stray_done = 0;
      pend_port = 0; pend_data = '0; last_start = 0;
      eng_valid = 1'b0;
      eng_data  = '0;
      forever begin
         @(negedge clk);
         eng_valid = 1'b0;
         if (!rst_n) begin
            cd = -1;
            exp_sel = 1'b0;
            have_last = 1'b0;
         end else begin
            if (!enable) have_last = 1'b0;
            if (cd == 0) begin
               eng_valid = 1'b1;
               eng_data  = {2'b01, pend_data};
               sb.push_back('{pend_port, pend_data, cyc + 2});
               cd = -1;
            end else if (cd > 0) begin
               cd--;
            end
            if (stray_cnt != stray_done) begin
               stray_done = stray_cnt;
               eng_valid  = 1'b1;
               eng_data   = {2'b10, 32'hDEAD_BEEF};
            end
            if (eng_start) begin
               n_starts++;
               chk("start_sel", {63'd0, eng_sel}, {63'd0, exp_sel});
               if (have_last) chk("slot_period", cyc - last_start, 64'd100);
               last_start = cyc;
               have_last  = 1'b1;
               if (resp_en[exp_sel]) begin
                  cd        = resp_delay - 1;
                  pend_port = int'(exp_sel);
                  pend_data = exp_sel ? data1 : data0;
               end
               exp_sel = ~exp_sel;
            end
         end
      end
   end

   // Monitor: every update pulse must match the oldest expected commit.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (upd0 || upd1)) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_upd: upd0=%0b upd1=%0b btn0=%0h btn1=%0h, none expected", upd0, upd1, btn0, btn1);
            end else begin
               e = sb.pop_front();
               chk("upd_port", upd1 ? 64'd1 : 64'd0, 64'(e.port));
               chk("upd_btn", upd1 ? {32'd0, btn1} : {32'd0, btn0}, {32'd0, e.btn});
               chk("upd_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic wait_starts(input int n);
      int tgt = n_starts + n;
      int k = 0;
      while (n_starts < tgt && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("start_seen", {63'd0, n_starts >= tgt}, 64'd1);
   endtask

   task automatic first_start(input string name);
      int n = 0;
      while (!eng_start && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(n), 64'd100);
   endtask

   initial begin
      int n_hold;
      rst_n = 1'b0; enable = 1'b0; enable2 = 1'b0;
      eng_valid2 = 1'b0; eng_data2 = '0;
      resp_en = 2'b00; resp_delay = 10; data0 = '0; data1 = '0; stray_cnt = 0;
      repeat (3) @(negedge clk);
      chk("rst_start", {63'd0, eng_start}, 64'd0);
      chk("rst_sel", {63'd0, eng_sel}, 64'd0);
      chk("rst_btn0", {32'd0, btn0}, 64'd0);
      chk("rst_btn1", {32'd0, btn1}, 64'd0);
      chk("rst_upd", {62'd0, upd1, upd0}, 64'd0);
      chk("rst_conn", {62'd0, conn}, 64'd0);
      chk("rst_overrun", {62'd0, overrun2, overrun}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: both ports answer after 10 cycles
      resp_en = 2'b11; data0 = 32'h0800_0000; data1 = 32'h0800_0000;
      enable = 1'b1;
      first_start("first_start_latency");
      wait_starts(2);
      repeat (15) @(negedge clk);
      chk("t1_conn", {62'd0, conn}, 64'd3);
      chk("t1_btn0", {32'd0, btn0}, 64'h0800_0000);
      chk("t1_btn1", {32'd0, btn1}, 64'h0800_0000);

      // 2: port 1 goes silent, drops after the third miss, then recovers
      resp_en = 2'b01; data0 = 32'h1111_0001;
      wait_starts(3);
      repeat (25) @(negedge clk);
      chk("t2_conn_two_miss", {62'd0, conn}, 64'd3);
      chk("t2_btn1_two_miss", {32'd0, btn1}, 64'h0800_0000);
      wait_starts(2);
      repeat (25) @(negedge clk);
      chk("t2_conn_dropped", {62'd0, conn}, 64'd1);
      chk("t2_btn1_neutral", {32'd0, btn1}, 64'd0);
      chk("t2_btn0_kept", {32'd0, btn0}, 64'h1111_0001);
      resp_en = 2'b11; data1 = 32'h2222_0002;
      wait_starts(2);
      repeat (15) @(negedge clk);
      chk("t2_conn_back", {62'd0, conn}, 64'd3);
      chk("t2_btn1_back", {32'd0, btn1}, 64'h2222_0002);

      // 3: response on the exact timeout cycle is a hit and clears the miss count
      resp_delay = 20; data0 = 32'h3333_0003; data1 = 32'h4444_0004;
      wait_starts(2);
      repeat (25) @(negedge clk);
      chk("t3_btn0", {32'd0, btn0}, 64'h3333_0003);
      chk("t3_btn1", {32'd0, btn1}, 64'h4444_0004);
      resp_en = 2'b01;
      wait_starts(4);
      repeat (25) @(negedge clk);
      chk("t3_conn_after_two_miss", {62'd0, conn}, 64'd3);
      resp_en = 2'b11; resp_delay = 10;
      stray_cnt++;
      repeat (5) @(negedge clk);
      chk("t3_stray_btn0", {32'd0, btn0}, 64'h3333_0003);
      chk("t3_stray_btn1", {32'd0, btn1}, 64'h4444_0004);

      // 4: enable dropped mid-AWAIT still commits, then no starts
      data0 = 32'h5555_0005;
      wait_starts(1);
      repeat (3) @(negedge clk);
      enable = 1'b0;
      repeat (30) @(negedge clk);
      chk("t4_btn0", {32'd0, btn0}, 64'h5555_0005);
      chk("t4_sel_toggled", {63'd0, eng_sel}, 64'd1);
      n_hold = n_starts;
      repeat (300) @(negedge clk);
      chk("t4_starts_while_off", 64'(n_starts - n_hold), 64'd0);
      data1 = 32'h6666_0006;
      enable = 1'b1;
      first_start("restart_latency");

      // 5: async reset during AWAIT
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5_start", {63'd0, eng_start}, 64'd0);
      chk("t5_sel", {63'd0, eng_sel}, 64'd0);
      chk("t5_btn0", {32'd0, btn0}, 64'd0);
      chk("t5_btn1", {32'd0, btn1}, 64'd0);
      chk("t5_conn", {62'd0, conn}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      first_start("post_reset_latency");
      repeat (15) @(negedge clk);
      chk("t5_btn0_after", {32'd0, btn0}, 64'h5555_0005);
      chk("t5_conn_after", {62'd0, conn}, 64'd1);
      enable = 1'b0;

      // 6: slot shorter than the await window sets sticky overrun
      chk("t6_overrun_before", {63'd0, overrun2}, 64'd0);
      enable2 = 1'b1;
      repeat (60) @(negedge clk);
      chk("t6_overrun_set", {63'd0, overrun2}, 64'd1);
      enable2 = 1'b0;
      repeat (100) @(negedge clk);
      chk("t6_overrun_sticky", {63'd0, overrun2}, 64'd1);
      chk("main_no_overrun", {63'd0, overrun}, 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
